// File: rtl/cordic_pkg.sv
// Shared types for the CORDIC front-panel controller: FSM states and display-select codes.
package cordic_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        WAIT   = 2'd2,
        HOLD   = 2'd3
    } state_t;

    localparam logic [1:0] SEL_ANGLE = 2'd0;
    localparam logic [1:0] SEL_COS   = 2'd1;
    localparam logic [1:0] SEL_SIN   = 2'd2;

    // Mode button rotates angle -> cos -> sin -> angle.
    function automatic logic [1:0] next_sel(input logic [1:0] sel);
        case (sel)
            SEL_ANGLE: next_sel = SEL_COS;
            SEL_COS:   next_sel = SEL_SIN;
            default:   next_sel = SEL_ANGLE;
        endcase
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Push-button conditioner: 2-flop synchroniser, consecutive-cycle debounce, press pulse on 1->0.
module btn_debounce #(
    parameter int DEB_CYCLES = 500000
) (
    input  logic clk_50,
    input  logic Reset,
    input  logic raw_n,
    output logic level,
    output logic press
);

    localparam int CW = $clog2(DEB_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(DEB_CYCLES - 1);

    logic          sync_1;
    logic          sync_2;
    logic [CW-1:0] count;

    always_ff @(posedge clk_50) begin
        if (!Reset) begin
            sync_1 <= 1'b1;
            sync_2 <= 1'b1;
            level  <= 1'b1;
            count  <= '0;
            press  <= 1'b0;
        end else begin
            sync_1 <= raw_n;
            sync_2 <= sync_1;
            press  <= 1'b0;
            // Any cycle where the input agrees with the level restarts the run.
            if (sync_2 == level) begin
                count <= '0;
            end else if (count == LAST) begin
                level <= sync_2;
                count <= '0;
                press <= level;
            end else begin
                count <= count + 1'b1;
            end
        end
    end

endmodule

// File: rtl/cordic_panel_ctrl.sv
// Front-panel controller: debounced Start/Mode, CORDIC launch/capture, display select.
// Optional watchdog on the WAIT state enabled by defining CORDIC_TIMEOUT_EN.
module cordic_panel_ctrl
    import cordic_pkg::*;
#(
    parameter int ANGLE_W        = 10,
    parameter int RES_W          = 17,
    parameter int FRAC_W         = 22,
    parameter int DEB_CYCLES     = 500000,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                        clk_50,
    input  logic                        Reset,
    input  logic                        start_n,
    input  logic                        mode_n,
    input  logic [ANGLE_W-1:0]          angle,
    output logic                        cordic_start,
    output logic [ANGLE_W+FRAC_W-1:0]   cordic_z0,
    input  logic                        cordic_done,
    input  logic [RES_W-1:0]            cos_in,
    input  logic [RES_W-1:0]            sin_in,
    output logic [RES_W-1:0]            disp_value,
    output logic [1:0]                  disp_sel,
    output logic                        busy,
    output logic                        Done,
    output logic                        err,
    output state_t                      fsm_state,
    output logic [1:0]                  btn_level
);

    if (RES_W < ANGLE_W || TIMEOUT_CYCLES < 1 || DEB_CYCLES < 1) begin : g_bad_params
        $error("cordic_panel_ctrl: invalid parameters");
    end

    state_t               state;
    logic [ANGLE_W-1:0]   z_reg;
    logic [RES_W-1:0]     cos_reg;
    logic [RES_W-1:0]     sin_reg;
    logic                 start_press;
    logic                 mode_press;
    logic                 start_level;
    logic                 mode_level;

    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_start_deb (
        .clk_50 (clk_50),
        .Reset  (Reset),
        .raw_n  (start_n),
        .level  (start_level),
        .press  (start_press)
    );

    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_mode_deb (
        .clk_50 (clk_50),
        .Reset  (Reset),
        .raw_n  (mode_n),
        .level  (mode_level),
        .press  (mode_press)
    );

`ifdef CORDIC_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TLAST = TW'(TIMEOUT_CYCLES - 1);
    logic [TW-1:0] timer;
    logic          err_r;
    assign err = err_r;
`else
    assign err = 1'b0;
`endif

    always_ff @(posedge clk_50) begin
        if (!Reset) begin
            state        <= IDLE;
            z_reg        <= '0;
            cos_reg      <= '0;
            sin_reg      <= '0;
            disp_sel     <= SEL_ANGLE;
            cordic_start <= 1'b0;
            busy         <= 1'b0;
            Done         <= 1'b0;
`ifdef CORDIC_TIMEOUT_EN
            timer        <= '0;
            err_r        <= 1'b0;
`endif
        end else begin
            cordic_start <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_press) begin
                        z_reg        <= angle;
                        state        <= LAUNCH;
                        cordic_start <= 1'b1;
                        busy         <= 1'b1;
`ifdef CORDIC_TIMEOUT_EN
                        err_r        <= 1'b0;
`endif
                    end
                end
                LAUNCH: begin
                    state <= WAIT;
`ifdef CORDIC_TIMEOUT_EN
                    timer <= '0;
`endif
                end
                WAIT: begin
                    if (cordic_done) begin
                        cos_reg  <= cos_in;
                        sin_reg  <= sin_in;
                        disp_sel <= SEL_COS;
                        state    <= HOLD;
                        busy     <= 1'b0;
                        Done     <= 1'b1;
                    end
`ifdef CORDIC_TIMEOUT_EN
                    else if (timer == TLAST) begin
                        state    <= IDLE;
                        busy     <= 1'b0;
                        err_r    <= 1'b1;
                        disp_sel <= SEL_ANGLE;
                    end else begin
                        timer <= timer + 1'b1;
                    end
`endif
                end
                HOLD: begin
                    // Start outranks Mode when both arrive together.
                    if (start_press) begin
                        z_reg        <= angle;
                        state        <= LAUNCH;
                        cordic_start <= 1'b1;
                        busy         <= 1'b1;
                        Done         <= 1'b0;
`ifdef CORDIC_TIMEOUT_EN
                        err_r        <= 1'b0;
`endif
                    end else if (mode_press) begin
                        disp_sel <= next_sel(disp_sel);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        disp_value = RES_W'($signed(z_reg));
        if (state == IDLE) begin
            disp_value = RES_W'($signed(angle));
        end else if (disp_sel == SEL_COS) begin
            disp_value = cos_reg;
        end else if (disp_sel == SEL_SIN) begin
            disp_value = sin_reg;
        end
    end

    assign cordic_z0 = {z_reg, {FRAC_W{1'b0}}};
    assign fsm_state = state;
    assign btn_level = {mode_level, start_level};

endmodule

// File: tb/tb_cordic_panel_ctrl.sv
// Directed + randomized bench for cordic_panel_ctrl with a behavioural CORDIC-core stand-in.
module tb_cordic_panel_ctrl;
    import cordic_pkg::*;

    localparam int DEB = 4;
    localparam int TMO = 32;

    logic         clk_50 = 1'b0;
    logic         Reset = 1'b0;
    logic         start_n = 1'b1;
    logic         mode_n = 1'b1;
    logic [9:0]   angle = '0;
    logic         cordic_start;
    logic [31:0]  cordic_z0;
    logic         cordic_done;
    logic [16:0]  cos_in = '0;
    logic [16:0]  sin_in = '0;
    logic [16:0]  disp_value;
    logic [1:0]   disp_sel;
    logic         busy;
    logic         Done;
    logic         err;
    state_t       fsm_state;
    logic [1:0]   btn_level;

    int n_asserts = 0;
    int n_fail = 0;

    logic model_en = 1'b0;
    logic model_done = 1'b0;
    logic manual_done = 1'b0;
    int   model_delay = 20;
    int   model_cnt = 0;
    int   launches = 0;

    assign cordic_done = model_done | manual_done;

    cordic_panel_ctrl #(
        .ANGLE_W(10), .RES_W(17), .FRAC_W(22), .DEB_CYCLES(DEB), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk_50(clk_50), .Reset(Reset), .start_n(start_n), .mode_n(mode_n), .angle(angle),
        .cordic_start(cordic_start), .cordic_z0(cordic_z0), .cordic_done(cordic_done),
        .cos_in(cos_in), .sin_in(sin_in), .disp_value(disp_value), .disp_sel(disp_sel),
        .busy(busy), .Done(Done), .err(err), .fsm_state(fsm_state), .btn_level(btn_level)
    );

    always #10 clk_50 = ~clk_50;

    // Stand-in core: counts launch pulses and answers model_delay cycles later.
    always @(negedge clk_50) begin
        model_done = 1'b0;
        if (cordic_start === 1'b1) begin
            launches++;
            if (model_en) model_cnt = model_delay;
        end else if (model_cnt > 0) begin
            model_cnt--;
            if (model_cnt == 0) model_done = 1'b1;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk_50);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic press_start();
        start_n = 1'b0;
        tick(DEB + 4);
        start_n = 1'b1;
        tick(DEB + 4);
    endtask

    task automatic press_mode();
        mode_n = 1'b0;
        tick(DEB + 4);
        mode_n = 1'b1;
        tick(DEB + 4);
    endtask

    task automatic wait_done();
        for (int i = 0; i < 200 && Done !== 1'b1; i++) tick(1);
        check("done_wait", Done, 1);
    endtask

    // Two's-complement reading of a 10-bit switch value, shown on 17 bits.
    function automatic logic [16:0] ang17(input logic [9:0] a);
        int v;
        v = (int'(a) >= 512) ? int'(a) - 1024 : int'(a);
        return v[16:0];
    endfunction

    function automatic logic [31:0] z0_of(input logic [9:0] a);
        return int'(a) * 32'h0040_0000;
    endfunction

    function automatic logic [16:0] view(input int sel, input logic [9:0] a,
                                         input logic [16:0] c, input logic [16:0] s);
        if (sel == 1) return c;
        if (sel == 2) return s;
        return ang17(a);
    endfunction

    initial begin
        int l0;
        int presses;
        int exp_sel;
        logic [9:0] a_r;

        // Reset and idle view
        angle = 10'd30;
        tick(3);
        Reset = 1'b1;
        tick(2);
        check("rst_sel", disp_sel, 0);
        check("rst_value", disp_value, 17'd30);
        check("rst_done", Done, 0);
        check("rst_z0", cordic_z0, 0);
        check("rst_busy", busy, 0);
        check("rst_err", err, 0);
        check("rst_start", cordic_start, 0);
        check("rst_state", fsm_state, IDLE);

        // First launch
        cos_in = 17'h0DDB3;
        sin_in = 17'h08000;
        model_delay = 20;
        model_en = 1'b1;
        l0 = launches;
        press_start();
        check("launch_once", launches, l0 + 1);
        check("launch_z0", cordic_z0, z0_of(10'd30));
        check("launch_busy", busy, 1);
        check("launch_notdone", Done, 0);
        wait_done();
        check("cap_value", disp_value, 17'h0DDB3);
        check("cap_sel", disp_sel, 1);
        check("cap_busy", busy, 0);

        // Mode cycling in HOLD
        press_mode();
        check("mode1_sel", disp_sel, 2);
        check("mode1_val", disp_value, 17'h08000);
        press_mode();
        check("mode2_sel", disp_sel, 0);
        check("mode2_val", disp_value, 17'd30);
        press_mode();
        check("mode3_sel", disp_sel, 1);
        check("mode3_val", disp_value, 17'h0DDB3);

        // Bouncing Start never settles long enough to launch
        l0 = launches;
        for (int i = 0; i < 6; i++) begin
            start_n = 1'b0;
            tick(1);
            start_n = 1'b1;
            tick(1);
        end
        tick(10);
        check("bounce_nolaunch", launches, l0);
        check("bounce_state", fsm_state, HOLD);
        check("bounce_done", Done, 1);

        // Random relaunches from HOLD with random mode presses
        for (int k = 0; k < 6; k++) begin
            a_r = 10'($urandom_range(0, 1023));
            angle = a_r;
            cos_in = 17'($urandom);
            sin_in = 17'($urandom);
            model_delay = $urandom_range(1, 30);
            l0 = launches;
            press_start();
            wait_done();
            check("rnd_launch", launches, l0 + 1);
            check("rnd_z0", cordic_z0, z0_of(a_r));
            check("rnd_cap", disp_value, cos_in);
            presses = $urandom_range(0, 4);
            for (int p = 0; p < presses; p++) press_mode();
            exp_sel = (1 + presses) % 3;
            check("rnd_sel", disp_sel, exp_sel);
            check("rnd_view", disp_value, view(exp_sel, a_r, cos_in, sin_in));
        end

        // Negative angle, live and latched; Mode ignored in IDLE
        Reset = 1'b0;
        tick(2);
        Reset = 1'b1;
        angle = 10'h3A6;
        tick(1);
        check("neg_live", disp_value, 17'h1FFA6);
        press_mode();
        check("idle_mode_sel", disp_sel, 0);
        check("idle_mode_state", fsm_state, IDLE);
        cos_in = 17'h00000;
        sin_in = 17'h1F000;
        model_delay = 5;
        press_start();
        wait_done();
        check("neg_z0", cordic_z0, z0_of(10'h3A6));
        press_mode();
        press_mode();
        check("neg_sel", disp_sel, 0);
        check("neg_latched", disp_value, 17'h1FFA6);

        // Reset in mid-WAIT, then a stray done
        model_en = 1'b0;
        angle = 10'd45;
        press_start();
        check("wait_state", fsm_state, WAIT);
        check("wait_busy", busy, 1);
        Reset = 1'b0;
        tick(2);
        Reset = 1'b1;
        manual_done = 1'b1;
        tick(1);
        manual_done = 1'b0;
        tick(2);
        check("late_state", fsm_state, IDLE);
        check("late_done", Done, 0);
        check("late_busy", busy, 0);
        check("late_sel", disp_sel, 0);
        check("late_z0", cordic_z0, 0);

`ifdef CORDIC_TIMEOUT_EN
        // Watchdog: no answer from the core
        angle = 10'd30;
        press_start();
        for (int i = 0; i < 100 && err !== 1'b1; i++) tick(1);
        check("tmo_err", err, 1);
        check("tmo_state", fsm_state, IDLE);
        check("tmo_busy", busy, 0);
        check("tmo_sel", disp_sel, 0);
        model_en = 1'b1;
        model_delay = 12;
        press_start();
        check("tmo_clear", err, 0);
        wait_done();
        check("tmo_recover", disp_value, cos_in);
`else
        check("no_err", err, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule

// File: doc/cordic_panel_ctrl.md
# cordic_panel_ctrl

Parametrised front-panel controller for the CORDIC demo. It debounces the Start and Mode push-buttons and latches the angle, then launches the external `cordic` core and captures both cosine and sine. It selects which of angle, cos or sin is driven to the `signed_to_7seg` display path. It replaces the fixed single-mode top-level logic: widths are generic, sine is viewable, buttons are debounced, and results are held until relaunch.

## Interface

Parameters:
- `ANGLE_W`, 10: width of the signed angle input, in integer degrees.
- `RES_W`, 17: width of the signed cos/sin results and `disp_value`. Must satisfy RES_W ≥ ANGLE_W.
- `FRAC_W`, 22: zero fraction bits appended to the angle to form `cordic_z0`.
- `DEB_CYCLES`, 500000: number of consecutive stable cycles before a debounced level changes.
- `TIMEOUT_CYCLES`, 1024: watchdog limit, used only with `CORDIC_TIMEOUT_EN`.

Ports:
- `clk_50` in 1: system clock.
- `Reset` in 1: synchronous, active-low reset.
- `start_n` in 1: raw Start button, active-low, asynchronous to the clock.
- `mode_n` in 1: raw Mode button, active-low, asynchronous to the clock.
- `angle` in ANGLE_W: signed angle from the switches.
- `cordic_start` out 1: one-cycle launch pulse to the core.
- `cordic_z0` out ANGLE_W+FRAC_W: the latched angle followed by FRAC_W zero bits.
- `cordic_done` in 1: completion flag from the core.
- `cos_in`, `sin_in` in RES_W: signed results from the core.
- `disp_value` out RES_W: signed number sent to the display.
- `disp_sel` out 2: 0 = angle, 1 = cos, 2 = sin.
- `busy` out 1: high in LAUNCH and WAIT.
- `Done` out 1: high in HOLD.
- `err` out 1: set on watchdog timeout. Tied to 0 when the macro is absent.

## Operation

Button handling:
- Each button passes through a 2-flop synchroniser and a debounce counter.
- The debounced level changes only after the synchronised input has differed from it for DEB_CYCLES consecutive cycles. Any bounce restarts the count.
- A press event is a one-cycle pulse on the debounced 1→0 transition.

FSM:
- IDLE: `disp_sel`=0 and `disp_value` shows the live `angle`, sign-extended. A Start press latches `angle` into `z_reg` and moves to LAUNCH.
- LAUNCH: `cordic_start`=1 for exactly this cycle, then move to WAIT.
- WAIT: on `cordic_done`=1, capture `cos_in` and `sin_in` into `cos_reg` and `sin_reg`, set `disp_sel`=1, and move to HOLD. Start and Mode presses are ignored.
- HOLD:
  - A Mode press cycles `disp_sel` 0→1→2→0.
  - `disp_value` is the latched angle (sign-extended), `cos_reg` or `sin_reg`, according to `disp_sel`.
  - A Start press re-latches `angle` and moves to LAUNCH. `disp_sel` keeps its value.

Other rules:
- `cordic_z0` = {z_reg, FRAC_W zeros} at all times.
- Mode presses in IDLE are ignored.
- Start and Mode pressed in the same HOLD cycle: Start wins and `disp_sel` is unchanged.
- A `cordic_done` seen outside WAIT is ignored.

Reset values (Reset=0 sampled at a clock edge):
- State IDLE.
- `z_reg`, `cos_reg`, `sin_reg` = 0.
- `disp_sel`=0, `cordic_start`=0, `busy`=0, `Done`=0, `err`=0.
- Debounced levels = 1 (released) and debounce counters = 0.
- Reset has priority over every other event, including in mid-WAIT. A late `cordic_done` after reset is ignored.

## Timing

- Start press latency: press pulse at cycle t → LAUNCH at t+1 (`cordic_start` high) → WAIT at t+2.
- Capture latency: `cordic_done` sampled high at cycle t → HOLD, `Done`=1 and new `disp_value` all at t+1.
- Mode press latency: `disp_sel` and `disp_value` update one cycle after the press pulse.
- Button latency: the raw edge appears as a press pulse after 2 + DEB_CYCLES cycles.
- All outputs are registered except `disp_value`, which is a mux of registered values and, in IDLE only, the live `angle`.

## Configuration

- `CORDIC_TIMEOUT_EN` defined:
  - A counter runs in WAIT. If it reaches TIMEOUT_CYCLES without `cordic_done`, go to IDLE and set `err`=1.
  - `err` clears on the next Start press or on reset.
- `CORDIC_TIMEOUT_EN` absent: no counter, `err` tied to 0, and WAIT waits indefinitely.

## Structure

- Shared package `cordic_pkg`:
  - State enum: IDLE, LAUNCH, WAIT, HOLD.
  - Display-select constants: SEL_ANGLE=0, SEL_COS=1, SEL_SIN=2.
- One sub-module, `btn_debounce` (parameter DEB_CYCLES; in raw_n, out level, press), instantiated twice.

## Test plan

Bench runs with DEB_CYCLES=4 and TIMEOUT_CYCLES=32.
- Reset, then angle=30: `disp_sel`=0, `disp_value`=30, `Done`=0, `cordic_z0`=0.
- Start pressed for 8 cycles with angle=30: exactly one `cordic_start` pulse, `cordic_z0`={30, 22'b0}, `busy`=1. Model asserts done after 20 cycles with cos=0x0DDB3, sin=0x08000 → `Done`=1, `disp_value`=0x0DDB3.
- In HOLD, three Mode presses: `disp_sel` goes 2, 0, 1 and `disp_value` goes sin, 30, cos. Start bouncing 1-0-1-0 at a 2-cycle period produces no launch.
- angle=-90 (10'h3A6): angle view shows 17-bit -90 (0x1FFA6).
- Reset asserted in WAIT, then `cordic_done` pulses: the FSM stays IDLE and `Done`=0.
- With `CORDIC_TIMEOUT_EN`, no done from the model: 32 cycles in WAIT → IDLE with `err`=1. The next Start press clears `err`.
